// File: rtl/diff_demo_pkg.sv
// Shared types and defaults for the PE row-stream block.
//   pe_rs_state_t   : control FSM states (IDLE, RUN, PUSH)
//   PE_RS_PSUM_W    : default partial-sum width
//   PE_RS_FIFO_D    : default number of buffered output rows
package diff_demo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PUSH = 2'd2
  } pe_rs_state_t;

  localparam int PE_RS_PSUM_W = 24;
  localparam int PE_RS_FIFO_D = 4;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO.
//   wr_en/wr_data : push (ignored when full in "block" mode)
//   rd_en/rd_data : pop; rd_data shows the head entry, 0 when empty
//   full/empty/count : occupancy status
module fifo_sync #(
  parameter int    WIDTH = 8,
  parameter int    DEPTH = 4,
  parameter string MODE  = "block",
  localparam int   AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int   CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNTW-1:0]  count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_wr, do_rd;

  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en && !empty;
  // In block mode a full FIFO refuses writes even if a pop frees a slot this cycle.
  assign do_wr = wr_en && (!full || (MODE != "block" && do_rd));

  // Gate the head so the output reads 0 whenever nothing is buffered.
  assign rd_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (do_rd) rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pe_row_stream.sv
// Streaming 1-D convolution row processing element.
// Activations arrive one per transfer; each kernel row of k taps is applied
// across a row of ROW_OUT+k-1 activations, accumulating ROW_OUT saturating
// partial sums. After k legal rows the psum bank is pushed into an output FIFO.
//   cfg_valid/cfg_k/act_signed : configuration, accepted only in IDLE
//   weight_i                   : w[r][t] at bits (r*KMAX+t)*ACT_WIDTH
//   act_*                      : activation stream (ready only in RUN)
//   out_*                      : psum rows, FWFT, psum[0] in LSBs
//   fifo_count/err_len/sat/busy: status
module pe_row_stream
  import diff_demo_pkg::*;
#(
  parameter int  ACT_WIDTH  = 8,
  parameter int  PSUM_WIDTH = PE_RS_PSUM_W,
  parameter int  ROW_OUT    = 6,
  parameter int  KMAX       = 5,
  parameter int  FIFO_DEPTH = PE_RS_FIFO_D,
  localparam int KW         = $clog2(KMAX + 1),
  localparam int FW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_valid,
  input  logic [KW-1:0]                   cfg_k,
  input  logic                            act_signed,
  input  logic [KMAX*KMAX*ACT_WIDTH-1:0]  weight_i,
  input  logic                            act_valid,
  output logic                            act_ready,
  input  logic [ACT_WIDTH-1:0]            act_data,
  input  logic                            act_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ROW_OUT*PSUM_WIDTH-1:0]   out_data,
  output logic [FW-1:0]                   fifo_count,
  output logic                            err_len,
  output logic                            sat,
  output logic                            busy
);

  localparam int CW = $clog2(ROW_OUT + KMAX);
  localparam int PW = 2 * ACT_WIDTH + 1;                     // product width
  localparam int SW = ((PSUM_WIDTH > PW) ? PSUM_WIDTH : PW) + 1;
  localparam logic signed [SW-1:0] PMAX = SW'({(PSUM_WIDTH-1){1'b1}});
  localparam logic signed [SW-1:0] PMIN = ~PMAX;

  pe_rs_state_t state;
  logic [KW-1:0] k_q;
  logic          sgn_q;
  logic [CW-1:0] col_cnt;
  logic [KW-1:0] row_cnt;
  logic [ROW_OUT-1:0][PSUM_WIDTH-1:0] bank, acc;
  logic [ROW_OUT-1:0]                 lane_clip;

  logic                  xfer, end_evt, legal, at_last_col, last_row;
  logic [CW-1:0]         last_col;
  logic signed [ACT_WIDTH:0] a_x;
  logic                  fifo_full, fifo_empty, fifo_wr;

  assign act_ready   = (state == ST_RUN);
  assign busy        = (state != ST_IDLE);
  assign xfer        = act_valid && act_ready;
  assign last_col    = CW'(ROW_OUT) + CW'(k_q) - CW'(2);
  assign at_last_col = (col_cnt == last_col);
  assign end_evt     = act_last || at_last_col;
  assign legal       = act_last && at_last_col;
  assign last_row    = (row_cnt == k_q - KW'(1));
  assign a_x         = {sgn_q & act_data[ACT_WIDTH-1], act_data};
  assign fifo_wr     = (state == ST_PUSH) && !fifo_full;

  // Lane j receives at most one product per transfer: tap t = col_cnt - j.
  for (genvar j = 0; j < ROW_OUT; j++) begin : g_lane
    logic signed [ACT_WIDTH-1:0]  w_sel;
    logic                         hit;
    logic signed [PW-1:0]         prod;
    logic signed [SW-1:0]         sum;
    logic signed [PSUM_WIDTH-1:0] nxt;
    logic                         clp;

    always_comb begin
      w_sel = '0;
      hit   = 1'b0;
      for (int t = 0; t < KMAX; t++) begin
        if (t < int'(k_q) && col_cnt == CW'(j + t)) begin
          hit   = 1'b1;
          w_sel = weight_i[(int'(row_cnt) * KMAX + t) * ACT_WIDTH +: ACT_WIDTH];
        end
      end
      prod = a_x * w_sel;
      if (hit) sum = SW'($signed(bank[j])) + SW'(prod);
      else     sum = SW'($signed(bank[j]));
      nxt = sum[PSUM_WIDTH-1:0];
      clp = 1'b0;
      if (sum > PMAX) begin
        nxt = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
        clp = 1'b1;
      end else if (sum < PMIN) begin
        nxt = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
        clp = 1'b1;
      end
    end

    assign acc[j]       = nxt;
    assign lane_clip[j] = clp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      k_q     <= KW'(1);
      sgn_q   <= 1'b0;
      col_cnt <= '0;
      row_cnt <= '0;
      bank    <= '0;
      err_len <= 1'b0;
      sat     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (cfg_valid) begin
          k_q     <= (cfg_k == '0 || cfg_k > KW'(KMAX)) ? KW'(1) : cfg_k;
          sgn_q   <= act_signed;
          col_cnt <= '0;
          row_cnt <= '0;
          state   <= ST_RUN;
        end
        ST_RUN: if (xfer) begin
          if (end_evt && !legal) begin
            // Misaligned row: drop everything gathered for this group.
            err_len <= 1'b1;
            bank    <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
          end else begin
            bank <= acc;
            if (|lane_clip) sat <= 1'b1;
            if (legal) begin
              col_cnt <= '0;
              if (last_row) begin
                row_cnt <= '0;
                state   <= ST_PUSH;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        ST_PUSH: if (!fifo_full) begin
          bank  <= '0;
          state <= ST_RUN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fifo_sync #(
    .WIDTH (ROW_OUT * PSUM_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .MODE  ("block")
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (bank),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_pe_row_stream.sv
// Directed bench for pe_row_stream. Three instances share stimulus:
// dut (defaults), dut_s (16-bit psums) and dut_f (2-deep FIFO).
module tb_pe_row_stream;

  localparam int AW = 8;
  localparam int KM = 5;

  logic clk, rst_n, cfg_valid, act_signed, act_valid, act_last, out_ready;
  logic [2:0] cfg_k;
  logic [KM*KM*AW-1:0] weight_i;
  logic [AW-1:0] act_data;

  logic         rdy0, ov0, err0, sat0, busy0;
  logic [143:0] od0;
  logic [2:0]   fc0;
  logic         rdy_s, ov_s, err_s, sat_s, busy_s;
  logic [95:0]  od_s;
  logic [2:0]   fc_s;
  logic         rdy_f, ov_f, err_f, sat_f, busy_f;
  logic [143:0] od_f;
  logic [1:0]   fc_f;

  int  sel;
  logic rdy_mon;
  int  n_chk, n_fail;

  assign rdy_mon = (sel == 2) ? rdy_f : rdy0;

  pe_row_stream dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_k(cfg_k), .act_signed(act_signed),
    .weight_i(weight_i), .act_valid(act_valid), .act_ready(rdy0), .act_data(act_data),
    .act_last(act_last), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .fifo_count(fc0), .err_len(err0), .sat(sat0), .busy(busy0));

  pe_row_stream #(.PSUM_WIDTH(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_k(cfg_k), .act_signed(act_signed),
    .weight_i(weight_i), .act_valid(act_valid), .act_ready(rdy_s), .act_data(act_data),
    .act_last(act_last), .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s),
    .fifo_count(fc_s), .err_len(err_s), .sat(sat_s), .busy(busy_s));

  pe_row_stream #(.FIFO_DEPTH(2)) dut_f (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_k(cfg_k), .act_signed(act_signed),
    .weight_i(weight_i), .act_valid(act_valid), .act_ready(rdy_f), .act_data(act_data),
    .act_last(act_last), .out_valid(ov_f), .out_ready(out_ready), .out_data(od_f),
    .fifo_count(fc_f), .err_len(err_f), .sat(sat_f), .busy(busy_f));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [143:0] row, input int base, input int step);
    for (int j = 0; j < 6; j++)
      chk($sformatf("%s psum%0d", tag, j), 64'(row[j*24 +: 24]), 64'(base + step * j));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cfg(input int k, input bit s);
    cfg_valid  = 1'b1;
    cfg_k      = 3'(k);
    act_signed = s;
    @(negedge clk);
    cfg_valid  = 1'b0;
  endtask

  task automatic set_w(input int v);
    for (int i = 0; i < KM * KM; i++) weight_i[i*AW +: AW] = 8'(v);
  endtask

  // Sends n activations start, start+step, ...; act_last on index last_idx.
  task automatic send_row(input int start, input int step, input int n, input int last_idx);
    int guard;
    for (int i = 0; i < n; i++) begin
      act_valid = 1'b1;
      act_data  = 8'(start + step * i);
      act_last  = (i == last_idx);
      guard = 0;
      while (!rdy_mon && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) chk("act_ready timeout", 64'(rdy_mon), 64'd1);
      @(negedge clk);
    end
    act_valid = 1'b0;
    act_last  = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    clk = 0; rst_n = 0; cfg_valid = 0; cfg_k = 0; act_signed = 0;
    act_valid = 0; act_last = 0; act_data = 0; out_ready = 0;
    weight_i = '0; sel = 0; n_chk = 0; n_fail = 0;

    // Reset state
    do_reset();
    chk("rst act_ready", 64'(rdy0), 0);
    chk("rst out_valid", 64'(ov0), 0);
    chk("rst out_data", 64'(od0 == '0), 1);
    chk("rst fifo_count", 64'(fc0), 0);
    chk("rst busy", 64'(busy0), 0);

    // k=1, w00=2, acts 1..6
    set_w(0); weight_i[7:0] = 8'd2;
    cfg(1, 0);
    chk("k1 busy", 64'(busy0), 1);
    send_row(1, 1, 6, 5);
    chk("k1 out_valid early", 64'(ov0), 0);
    @(negedge clk);
    chk("k1 out_valid", 64'(ov0), 1);
    chk_row("k1", od0, 2, 2);
    chk("k1 fifo_count", 64'(fc0), 1);
    pop();
    chk("k1 out_valid after pop", 64'(ov0), 0);
    chk("k1 out_data after pop", 64'(od0 == '0), 1);

    // k=3, all ones, three rows 1..8
    do_reset();
    set_w(1);
    cfg(3, 0);
    for (int r = 0; r < 3; r++) send_row(1, 1, 8, 7);
    @(negedge clk);
    chk_row("k3", od0, 18, 9);
    chk("k3 sat", 64'(sat0), 0);

    // Saturation with 16-bit psums
    do_reset();
    set_w(127);
    cfg(3, 1);
    for (int r = 0; r < 3; r++) send_row(127, 0, 8, 7);
    @(negedge clk);
    for (int j = 0; j < 6; j++)
      chk($sformatf("sat16 psum%0d", j), 64'(od_s[j*16 +: 16]), 64'h7fff);
    chk("sat16 sat", 64'(sat_s), 1);
    chk_row("sat24", od0, 145161, 0);
    chk("sat24 sat", 64'(sat0), 0);

    // 2-deep FIFO backpressure; cfg_k=7 is out of range -> k=1
    do_reset();
    set_w(0); weight_i[7:0] = 8'd2;
    cfg(7, 0);
    sel = 2;
    send_row(1, 0, 6, 5);
    send_row(2, 0, 6, 5);
    send_row(3, 0, 6, 5);
    @(negedge clk);
    chk("bp fifo_count full", 64'(fc_f), 2);
    chk("bp act_ready held", 64'(rdy_f), 0);
    chk("bp busy", 64'(busy_f), 1);
    chk("bp head row1", 64'(od_f[23:0]), 2);
    pop();
    chk("bp count after pop", 64'(fc_f), 1);
    chk("bp still PUSH", 64'(rdy_f), 0);
    chk("bp head row2", 64'(od_f[23:0]), 4);
    @(negedge clk);
    chk("bp count refill", 64'(fc_f), 2);
    chk("bp act_ready back", 64'(rdy_f), 1);
    pop();
    chk("bp head row3 lane0", 64'(od_f[23:0]), 6);
    chk("bp head row3 lane5", 64'(od_f[143:120]), 6);
    pop();
    chk("bp drained", 64'(ov_f), 0);
    sel = 0;

    // Short row -> err_len, then a legal group
    do_reset();
    set_w(1);
    cfg(3, 0);
    send_row(1, 1, 5, 4);
    @(negedge clk);
    chk("len err_len", 64'(err0), 1);
    chk("len nothing pushed", 64'(fc0), 0);
    chk("len busy", 64'(busy0), 1);
    for (int r = 0; r < 3; r++) send_row(1, 1, 8, 7);
    @(negedge clk);
    chk_row("len recover", od0, 18, 9);
    chk("len err sticky", 64'(err0), 1);

    // Reset mid-row with one row buffered
    send_row(1, 1, 3, -1);
    chk("mid buffered", 64'(fc0), 1);
    rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", 64'(ov0), 0);
    chk("mid rst out_data", 64'(od0 == '0), 1);
    chk("mid rst fifo_count", 64'(fc0), 0);
    chk("mid rst err_len", 64'(err0), 0);
    chk("mid rst busy", 64'(busy0), 0);
    chk("mid rst act_ready", 64'(rdy0), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cfg(3, 0);
    for (int r = 0; r < 3; r++) send_row(1, 1, 8, 7);
    @(negedge clk);
    chk_row("post rst", od0, 18, 9);
    chk("post rst fifo_count", 64'(fc0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_row_stream.md
PE_ROW_STREAM -- requirements
Module: pe_row_stream

Interface
REQ-001 Parameters: ACT_WIDTH, default 8, activation/weight bit width.
REQ-002 Parameters: PSUM_WIDTH, default 24, signed psum width.
REQ-003 Parameters: ROW_OUT, default 6, output psums per row.
REQ-004 Parameters: KMAX, default 5, maximum kernel size.
REQ-005 Parameters: FIFO_DEPTH, default 4, output rows buffered.
REQ-006 Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- cfg_valid  in  1  config strobe.
- cfg_k  in  clog2(KMAX+1)  kernel size 1..KMAX.
- act_signed  in  1  1 = signed activation, 0 = zero-extend.
- weight_i  in  KMAX*KMAX*ACT_WIDTH  signed weights w[r][t], r = kernel row, t = tap.
- act_valid  in  1  activation handshake.
- act_ready  out  1  activation handshake.
- act_data  in  ACT_WIDTH  activation.
- act_last  in  1  last activation of row.
- out_valid  out  1  output handshake.
- out_ready  in  1  output handshake.
- out_data  out  ROW_OUT*PSUM_WIDTH  psum row, psum[0] in LSBs.
- fifo_count  out  clog2(FIFO_DEPTH+1)  rows buffered.
- err_len  out  1  sticky row-length error.
- sat  out  1  sticky saturation.
- busy  out  1  state != IDLE.

Function
REQ-007 States: IDLE, RUN, PUSH; IDLE->RUN on cfg_valid, latching k = cfg_k and act_signed; cfg_valid outside IDLE ignored; cfg_k of 0 or >KMAX is treated as 1.
REQ-008 act_ready = 1 only in RUN; a transfer happens when act_valid && act_ready.
REQ-009 Row length L = ROW_OUT+k-1; col_cnt counts transfers 0..L-1; row_cnt counts kernel rows 0..k-1.
REQ-010 Per transfer at column c, for every t<k with 0<=c-t<ROW_OUT: psum[c-t] += a*w[row_cnt][t].
REQ-011 Arithmetic is full-precision signed, saturating to PSUM_WIDTH; any clip sets sat.
REQ-012 A row ends on act_last or at col_cnt==L-1; the end is legal only if both hold.
REQ-013 Illegal row end: set err_len, clear the psum bank, reset row_cnt and col_cnt, push nothing.
REQ-014 Legal row end with row_cnt<k-1: row_cnt++, col_cnt=0.
REQ-015 Legal row end with row_cnt==k-1: go to PUSH, col_cnt=0, row_cnt=0.
REQ-016 PUSH: if FIFO not full, write the bank, clear the bank, return to RUN; otherwise hold in PUSH.
REQ-017 Write when full is blocked even if a read occurs the same cycle.
REQ-018 Latency: last transfer at cycle n -> FIFO write at n+1 (if not full) -> out_valid at n+2 when the FIFO was empty.
REQ-019 out_valid = FIFO not empty; out_data is the head entry (first-word-fall-through); a pop happens on out_valid && out_ready.
REQ-020 A simultaneous write and pop keeps fifo_count unchanged.
REQ-021 Weights are sampled per transfer; weight_i must be held stable while busy.

Reset
REQ-022 rst_n low immediately forces: state IDLE, act_ready 0, out_valid 0, out_data 0, fifo_count 0, err_len 0, sat 0, busy 0, bank 0, counters 0, FIFO emptied.
REQ-023 Reset mid-row discards all partial and buffered data.
REQ-024 err_len and sat clear only on reset.

Structure
REQ-025 The state enum pe_rs_state_t and the default PSUM_WIDTH and FIFO_DEPTH constants live in diff_demo_pkg.
REQ-026 The output buffer is one fifo_sync instance: width ROW_OUT*PSUM_WIDTH, depth FIFO_DEPTH, mode "block".
REQ-027 MAC lanes are inline generate logic, with no further sub-modules.

Verification
REQ-028 k=1, w[0][0]=2, acts 1..6 (last on 6th) -> one row out: 2,4,6,8,10,12; out_valid 2 cycles after the last transfer.
REQ-029 k=3, all weights 1, three rows of acts 1..8 -> psum[j]=9j+18: 18,27,36,45,54,63.
REQ-030 PSUM_WIDTH=16, k=3, weights 127, acts 127 signed -> all psums 32767, sat=1.
REQ-031 FIFO_DEPTH=2, out_ready=0, three groups -> fifo_count=2, PUSH held, act_ready=0; one pop -> third row written next cycle, fifo_count back to 2.
REQ-032 k=3, act_last on 5th activation -> err_len=1, nothing pushed; the following legal group gives the REQ-029 result.
REQ-033 rst_n low mid-row with 1 row buffered -> all outputs 0 at once; after cfg, the next group is correct.
